// File: rtl/pdm_meter_pkg.sv
// Shared constants and width helpers for the PDM level meter and its window sum.
package pdm_meter_pkg;

  function automatic int mid_scale(input int win_log2);
    return 32'sd1 << (win_log2 - 32'sd1);
  endfunction

  function automatic int level_width(input int win_log2);
    return win_log2;
  endfunction

  function automatic int sum_width(input int win_log2);
    return win_log2 + 32'sd1;
  endfunction

  // Bits needed to hold 0..value-1, never fewer than one.
  function automatic int clog2(input int value);
    int bits;
    bits = 32'sd1;
    while ((32'sd1 << bits) < value) begin
      bits = bits + 32'sd1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pdm_window_sum.sv
// Circular buffer of the last 2^WIN_LOG2 PDM bits with a running ones-count
// and a fill counter that saturates once the window is full.
module pdm_window_sum
  import pdm_meter_pkg::*;
#(
  parameter int WIN_LOG2 = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic              data,
  output logic [WIN_LOG2:0] sum,
  output logic              fill_done,
  output logic              sum_strobe
);

  localparam int DEPTH = 32'sd1 << WIN_LOG2;
  localparam int SW = sum_width(WIN_LOG2);
  localparam logic [SW-1:0] FULL = SW'(DEPTH);

  logic [DEPTH-1:0]    window_r;
  logic [WIN_LOG2-1:0] ptr_r;
  logic [SW-1:0]       fill_r;
  logic [SW-1:0]       sum_r;
  logic                strobe_r;
  logic                oldest_s;

  assign oldest_s = window_r[ptr_r];

  // The bit leaving the window is read at the pointer before the new bit overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_r <= '0;
      ptr_r    <= '0;
      fill_r   <= '0;
      sum_r    <= '0;
      strobe_r <= 1'b0;
    end else if (clear) begin
      window_r <= '0;
      ptr_r    <= '0;
      fill_r   <= '0;
      sum_r    <= '0;
      strobe_r <= 1'b0;
    end else begin
      strobe_r <= valid;
      if (valid) begin
        window_r[ptr_r] <= data;
        ptr_r           <= ptr_r + WIN_LOG2'(1);
        sum_r           <= sum_r + SW'(data) - SW'(oldest_s);
        if (fill_r != FULL) begin
          fill_r <= fill_r + SW'(1);
        end
      end
    end
  end

  assign sum        = sum_r;
  assign fill_done  = (fill_r == FULL);
  assign sum_strobe = strobe_r;

endmodule

// File: rtl/pdm_level_meter.sv
// PDM amplitude meter: deviation from mid-scale, LED thermometer bar,
// peak-hold with timed decay and a sticky clip flag.
module pdm_level_meter
  import pdm_meter_pkg::*;
#(
  parameter int WIN_LOG2   = 7,
  parameter int NUM_LEDS   = 16,
  parameter int BAR_SHIFT  = 2,
  parameter int PEAK_HOLD  = 4096,
  parameter int PEAK_DECAY = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pdm_valid_i,
  input  logic                pdm_data_i,
  input  logic                clear_i,
  output logic [WIN_LOG2-1:0] level_o,
  output logic                level_valid_o,
  output logic [NUM_LEDS-1:0] bar_o,
  output logic [WIN_LOG2-1:0] peak_o,
  output logic                clip_o
);

  localparam int LW = level_width(WIN_LOG2);
  localparam int SW = sum_width(WIN_LOG2);
  localparam int HW = clog2(PEAK_HOLD + 32'sd1);
  localparam int DW = clog2(PEAK_DECAY);
  localparam logic [SW-1:0] MID_SUM    = SW'(mid_scale(WIN_LOG2));
  localparam logic [HW-1:0] HOLD_INIT  = HW'(PEAK_HOLD);
  localparam logic [DW-1:0] DECAY_LAST = DW'(PEAK_DECAY - 32'sd1);

  logic [SW-1:0]       sum_s;
  logic                fill_done_s;
  logic                sum_strobe_s;
  logic [SW-1:0]       dev_s;
  logic [LW-1:0]       level_next_s;
  logic [LW-1:0]       shifted_s;
  logic [NUM_LEDS-1:0] bar_next_s;
  logic                clip_hit_s;

  logic [LW-1:0]       level_r;
  logic                level_valid_r;
  logic [NUM_LEDS-1:0] bar_r;
  logic                clip_r;
  logic                level_strobe_r;
  logic [LW-1:0]       peak_r;
  logic [HW-1:0]       hold_r;
  logic [DW-1:0]       decay_r;

  pdm_window_sum #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (clear_i),
    .valid      (pdm_valid_i),
    .data       (pdm_data_i),
    .sum        (sum_s),
    .fill_done  (fill_done_s),
    .sum_strobe (sum_strobe_s)
  );

  // Absolute distance of the ones-count from mid-scale.
  always_comb begin
    dev_s = '0;
    if (sum_s >= MID_SUM) begin
      dev_s = sum_s - MID_SUM;
    end else begin
      dev_s = MID_SUM - sum_s;
    end
  end

  // Until the window is full the level is meaningless, so it reads as silence.
  assign level_next_s = fill_done_s ? dev_s[LW-1:0] : '0;
  assign clip_hit_s   = fill_done_s && (dev_s == MID_SUM);
  assign shifted_s    = level_next_s >> BAR_SHIFT;

  // Thermometer code; levels beyond the bar simply light every LED.
  always_comb begin
    bar_next_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bar_next_s[i] = (32'(shifted_s) > 32'(i));
    end
  end

  // Level, bar, valid and clip stage, one cycle behind the running sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_r        <= '0;
      level_valid_r  <= 1'b0;
      bar_r          <= '0;
      clip_r         <= 1'b0;
      level_strobe_r <= 1'b0;
    end else if (clear_i) begin
      level_r        <= '0;
      level_valid_r  <= 1'b0;
      bar_r          <= '0;
      clip_r         <= 1'b0;
      level_strobe_r <= 1'b0;
    end else begin
      level_strobe_r <= sum_strobe_s;
      if (sum_strobe_s) begin
        level_r       <= level_next_s;
        level_valid_r <= fill_done_s;
        bar_r         <= bar_next_s;
        clip_r        <= clip_r | clip_hit_s;
      end
    end
  end

  // Peak-hold: a new maximum restarts the hold; afterwards the peak sinks one
  // LSB per decay period but is never allowed below the present level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_r  <= '0;
      hold_r  <= '0;
      decay_r <= '0;
    end else if (clear_i) begin
      peak_r  <= '0;
      hold_r  <= '0;
      decay_r <= '0;
    end else if (level_strobe_r) begin
      if (level_r > peak_r) begin
        peak_r <= level_r;
        hold_r <= HOLD_INIT;
      end else if (hold_r != '0) begin
        hold_r  <= hold_r - HW'(1);
        decay_r <= '0;
      end else if (decay_r == DECAY_LAST) begin
        decay_r <= '0;
        peak_r  <= (peak_r > level_r) ? (peak_r - LW'(1)) : level_r;
      end else begin
        decay_r <= decay_r + DW'(1);
      end
    end
  end

  assign level_o       = level_r;
  assign level_valid_o = level_valid_r;
  assign bar_o         = bar_r;
  assign clip_o        = clip_r;
  assign peak_o        = peak_r;

endmodule

// File: tb/tb_pdm_level_meter.sv
// Scoreboard bench for pdm_level_meter: a queue-based window model predicts
// every level update and peak update; a negedge monitor checks them.
module tb_pdm_level_meter;

  localparam int W     = 7;
  localparam int N     = 16;
  localparam int BS    = 2;
  localparam int PH    = 8;
  localparam int PD    = 2;
  localparam int DEPTH = 128;
  localparam int MID   = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pdm_valid = 1'b0;
  logic         pdm_data = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] level;
  logic         level_valid;
  logic [N-1:0] bar;
  logic [W-1:0] peak;
  logic         clip;

  pdm_level_meter #(
    .WIN_LOG2   (W),
    .NUM_LEDS   (N),
    .BAR_SHIFT  (BS),
    .PEAK_HOLD  (PH),
    .PEAK_DECAY (PD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pdm_valid_i   (pdm_valid),
    .pdm_data_i    (pdm_data),
    .clear_i       (clear),
    .level_o       (level),
    .level_valid_o (level_valid),
    .bar_o         (bar),
    .peak_o        (peak),
    .clip_o        (clip)
  );

  always #5 clk = ~clk;

  typedef struct {
    int level;
    int bar;
    int clip;
    int valid;
  } exp_t;

  exp_t lvl_q[$];
  int   peak_q[$];
  int   checks = 0;
  int   errors = 0;

  bit   hist[$];
  int   m_clip, m_peak, m_hold, m_decay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_clip  = 0;
    m_peak  = 0;
    m_hold  = 0;
    m_decay = 0;
  endtask

  // Reference: recount the last DEPTH bits from scratch on every sample.
  task automatic model_step(input bit d);
    int   ones, lvl, cnt;
    exp_t e;
    hist.push_back(d);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    ones = 0;
    foreach (hist[i]) ones += int'(hist[i]);
    e.valid = (hist.size() == DEPTH) ? 1 : 0;
    lvl = (e.valid == 0) ? 0 : ((ones >= MID) ? ones - MID : MID - ones);
    cnt = lvl >> BS;
    if (cnt > N) cnt = N;
    if (e.valid == 1 && lvl == MID) m_clip = 1;
    e.level = lvl;
    e.bar   = (1 << cnt) - 1;
    e.clip  = m_clip;
    if (lvl > m_peak) begin
      m_peak = lvl;
      m_hold = PH;
    end else if (m_hold > 0) begin
      m_hold--;
      m_decay = 0;
    end else if (m_decay == PD - 1) begin
      m_decay = 0;
      if (m_peak > lvl) m_peak--;
    end else begin
      m_decay++;
    end
    lvl_q.push_back(e);
    peak_q.push_back(m_peak);
  endtask

  task automatic drive(input bit v, input bit d);
    @(posedge clk);
    #1;
    pdm_valid = v;
    pdm_data  = d;
    if (v) model_step(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_valid"}, 32'(level_valid), 32'd0);
    check({tag, "_bar"},   32'(bar), 32'd0);
    check({tag, "_peak"},  32'(peak), 32'd0);
    check({tag, "_clip"},  32'(clip), 32'd0);
  endtask

  task automatic do_clear();
    idle(5);
    @(posedge clk);
    #1;
    clear     = 1'b1;
    pdm_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_zero("clear");
  endtask

  task automatic random_phase(input int n, input int density, input bit gaps);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, ($urandom_range(0, 99) < density));
      if (gaps && $urandom_range(0, 3) == 0) drive(1'b0, 1'b0);
    end
  endtask

  // Monitor: an update is due two cycles after its strobe, the peak three.
  initial begin
    logic [2:0] pipe;
    exp_t e;
    int   p;
    pipe = 3'b000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pipe[1]) begin
          if (lvl_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL level_queue actual empty required entry");
          end else begin
            e = lvl_q.pop_front();
            check("sb_level", 32'(level), 32'(e.level));
            check("sb_bar",   32'(bar),   32'(e.bar));
            check("sb_clip",  32'(clip),  32'(e.clip));
            check("sb_valid", 32'(level_valid), 32'(e.valid));
          end
        end
        if (pipe[2]) begin
          if (peak_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL peak_queue actual empty required entry");
          end else begin
            p = peak_q.pop_front();
            check("sb_peak", 32'(peak), 32'(p));
          end
        end
      end
      if (rst || clear) begin
        pipe = 3'b000;
        lvl_q.delete();
        peak_q.delete();
      end else begin
        pipe = {pipe[1:0], pdm_valid};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Fill boundary: 127 strobes keep valid low, the 128th raises it.
    random_phase(127, 50, 1'b0);
    idle(4);
    check("fill127_valid", 32'(level_valid), 32'd0);
    drive(1'b1, 1'b1);
    idle(4);
    check("fill128_valid", 32'(level_valid), 32'd1);

    random_phase(150, 80, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    pdm_valid = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    idle(2);
    rst = 1'b0;

    // Balanced, then saturation into clip, then back to balanced.
    for (int i = 0; i < 300; i++) drive(1'b1, i[0]);
    idle(4);
    check("balanced_level", 32'(level), 32'd0);
    check("balanced_clip",  32'(clip),  32'd0);
    for (int i = 0; i < 128; i++) drive(1'b1, 1'b1);
    idle(4);
    check("allones_level", 32'(level), 32'd64);
    check("allones_bar",   32'(bar),   32'hFFFF);
    check("allones_clip",  32'(clip),  32'd1);
    for (int i = 0; i < 256; i++) drive(1'b1, i[0]);
    idle(4);
    check("sticky_level", 32'(level), 32'd0);
    check("sticky_clip",  32'(clip),  32'd1);
    do_clear();

    // Bar step points: level 20 and level 3.
    for (int i = 0; i < 84; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 44; i++) drive(1'b1, 1'b0);
    idle(4);
    check("bar20_level", 32'(level), 32'd20);
    check("bar20_bar",   32'(bar),   32'h001F);
    do_clear();
    for (int i = 0; i < 67; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 61; i++) drive(1'b1, 1'b0);
    idle(4);
    check("bar3_level", 32'(level), 32'd3);
    check("bar3_bar",   32'(bar),   32'd0);

    // Peak hold then decay: push level to 40, then walk it down.
    do_clear();
    for (int i = 0; i < 104; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 120; i++) drive(1'b1, i[0]);
    random_phase(100, 50, 1'b1);

    // Clear colliding with a strobe drops the sample and restarts the fill.
    idle(5);
    @(posedge clk);
    #1;
    clear     = 1'b1;
    pdm_valid = 1'b1;
    pdm_data  = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    clear     = 1'b0;
    pdm_valid = 1'b0;
    check_zero("collide");
    random_phase(127, 30, 1'b1);
    idle(4);
    check("collide127_valid", 32'(level_valid), 32'd0);
    drive(1'b1, 1'b0);
    idle(4);
    check("collide128_valid", 32'(level_valid), 32'd1);

    for (int ph = 0; ph < 6; ph++) begin
      random_phase(200, $urandom_range(0, 100), ph[0]);
    end
    idle(6);
    check("queues_drained", 32'(lvl_q.size() + peak_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_level_meter.md
# pdm_level_meter

Parametrised PDM amplitude meter for the microphone front end. It sits after the PDM clock/capture logic and before the LED bar and 7-segment display drivers. It keeps a sliding ones-count over a power-of-two window of PDM bits and derives the absolute deviation from mid-scale as the level. From the level it produces a thermometer bar, a peak-hold value with decay, and a sticky clip flag. The whole block runs in the system clock domain, and samples arrive as one-cycle strobes rather than on the PDM clock edge.

## Interface
Parameters:
- WIN_LOG2, 7: window depth is 2^WIN_LOG2 PDM bits (range 3..10).
- NUM_LEDS, 16: bar width.
- BAR_SHIFT, 2: level right-shift before thermometer encoding.
- PEAK_HOLD, 4096: sample strobes for which a new peak is held before decay starts.
- PEAK_DECAY, 256: sample strobes per 1-LSB peak decrement once hold expires.

Ports:
- clk_i  in  1  system clock (100 MHz).
- rst_i  in  1  asynchronous, active-high reset.
- pdm_valid_i  in  1  one-cycle strobe: pdm_data_i is a new PDM bit.
- pdm_data_i  in  1  PDM bit, sampled only when pdm_valid_i=1.
- clear_i  in  1  synchronous clear (debounced button); same effect as reset.
- level_o  out  WIN_LOG2  |ones_count − 2^(WIN_LOG2−1)|, range 0..2^(WIN_LOG2−1).
- level_valid_o  out  1  high once the window has been filled since reset/clear.
- bar_o  out  NUM_LEDS  thermometer: bar_o[i] = (i < min(level_o>>BAR_SHIFT, NUM_LEDS)).
- peak_o  out  WIN_LOG2  peak-hold of level_o.
- clip_o  out  1  sticky: set when level_o reaches 2^(WIN_LOG2−1).

## Operation
- Window storage is a 2^WIN_LOG2 × 1 circular buffer with a WIN_LOG2-bit write pointer. On each strobe:
  - the oldest bit is read at the pointer, the new bit is written there, and the pointer increments, wrapping from 2^WIN_LOG2−1 to 0;
  - the running sum (WIN_LOG2+1 bits) updates as sum + new − oldest, with no overflow possible.
- Fill counter: counts strobes and saturates at 2^WIN_LOG2. level_valid_o rises on the strobe that completes the window. While it is low, level_o, bar_o and peak_o are forced to 0 and clip_o is not set.
- Level is computed as: if sum ≥ 2^(WIN_LOG2−1) then sum − 2^(WIN_LOG2−1), else 2^(WIN_LOG2−1) − sum.
- Peak is updated once per level update:
  - if level > peak: peak ← level and hold_cnt ← PEAK_HOLD;
  - else if hold_cnt > 0: hold_cnt decrements and decay_cnt ← 0;
  - else decay_cnt counts strobes, and on reaching PEAK_DECAY−1 it wraps and peak ← max(peak−1, level).
  - Peak never falls below the current level.
- Clip: set when level = 2^(WIN_LOG2−1) (all-ones or all-zeros window). Cleared only by rst_i or clear_i.
- clear_i clears the buffer, sum, pointer, fill counter, peak, counters and clip. If clear_i and pdm_valid_i are high in the same cycle, clear wins and the sample is dropped.
- Reset values: all outputs are 0; internal state is 0.
- Reset asserted mid-window discards all history, and the next window fill starts from 0.

## Timing
- Strobe at cycle t: the sum register is updated at t+1.
- level_o, bar_o, clip_o and level_valid_o are registered at t+2.
- peak_o is registered at t+3.
- Strobes may arrive every cycle. Back-to-back strobes are fully pipelined with no stalls and no handshake back-pressure.
- Outputs hold their value between strobes.
- clear_i takes effect at the next edge; all outputs read 0 the cycle after.

## Structure
- Package pdm_meter_pkg holds:
  - the mid-scale constant function (2^(WIN_LOG2−1));
  - the level width, WIN_LOG2;
  - the sum width, WIN_LOG2+1;
  - a clog2 helper for counter widths derived from PEAK_HOLD and PEAK_DECAY.
- Sub-module pdm_window_sum contains the circular buffer, pointer, fill counter and running sum, and outputs sum and fill-done.
- The top level contains the deviation, thermometer, peak-hold and clip logic.

## Test plan
- **Reset:** assert rst_i mid-run → all outputs 0 immediately. After release, feed 127 strobes → level_valid_o stays 0; the 128th strobe → level_valid_o=1 at t+2.
- **Balanced input:** alternating 1/0 at every strobe for 300 strobes (WIN_LOG2=7) → level_o=0, bar_o=0, clip_o=0.
- **All ones:** 128 strobes with data=1 → level_o=64, bar_o=16'hFFFF, clip_o=1. Then alternating data → level_o falls back to 0 and clip_o stays 1 until clear_i.
- **Bar step:** window holding 84 ones (level 20) → bar_o=16'h001F (5 LEDs). Check level 3 → bar_o=0.
- **Peak hold/decay:** with PEAK_HOLD=8 and PEAK_DECAY=2, drive level to 40 then to 0 → peak_o=40 for 8 strobes, then decrements by 1 every 2 strobes down to 0.
- **Clear collision:** clear_i and pdm_valid_i in the same cycle → sample dropped, the fill counter restarts at 0, and 128 further strobes are needed before level_valid_o=1.
